// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard receiver: synchronises and glitch-filters the pins, validates
// 11-bit frames and turns make/break sequences into the held game key code.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       frame_err
);
    localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] KEY_NONE = 4'h0;
    localparam logic [3:0] KEY_A    = 4'h1;
    localparam logic [3:0] KEY_D    = 4'h2;
    localparam logic [3:0] KEY_W    = 4'h3;
    localparam logic [3:0] KEY_S    = 4'h4;
    localparam logic [3:0] KEY_E    = 4'h5;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    function automatic logic [3:0] map_key(input logic [7:0] code);
        case (code)
            8'h1C:   map_key = KEY_A;
            8'h23:   map_key = KEY_D;
            8'h1D:   map_key = KEY_W;
            8'h1B:   map_key = KEY_S;
            8'h24:   map_key = KEY_E;
            default: map_key = KEY_NONE;
        endcase
    endfunction

    // Stage: 2-FF synchronisers; idle-high so reset does not fake an edge.
    logic clk_s0, clk_s1, data_s0, data_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s0  <= 1'b1;
            clk_s1  <= 1'b1;
            data_s0 <= 1'b1;
            data_s1 <= 1'b1;
        end else begin
            clk_s0  <= ps2_clk;
            clk_s1  <= clk_s0;
            data_s0 <= ps2_data;
            data_s1 <= data_s0;
        end
    end

    // Stage p0: glitch filter; a falling filtered edge becomes strobe_p0.
    logic              filt_clk;
    logic [FILT_W-1:0] filt_cnt;
    logic              strobe_p0;
    logic              bit_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_clk  <= 1'b1;
            filt_cnt  <= '0;
            strobe_p0 <= 1'b0;
        end else begin
            strobe_p0 <= 1'b0;
            if (clk_s1 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
                filt_clk  <= clk_s1;
                filt_cnt  <= '0;
                strobe_p0 <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        bit_p0 <= data_s1;
    end

    // Stage p1: frame assembly, parity/stop validation and partial-frame timeout.
    typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_t;

    frame_t           fstate;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             parity;
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            fstate         <= F_IDLE;
            bit_cnt        <= 3'd0;
            shift          <= 8'h00;
            parity         <= 1'b0;
            tmo_cnt        <= '0;
            scancode       <= 8'h00;
            scancode_valid <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            scancode_valid <= 1'b0;
            frame_err      <= 1'b0;
            if (strobe_p0) begin
                tmo_cnt <= '0;
                case (fstate)
                    F_IDLE: begin
                        if (!bit_p0) begin
                            fstate  <= F_DATA;
                            bit_cnt <= 3'd0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    F_DATA: begin
                        shift   <= {bit_p0, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            fstate <= F_PARITY;
                        end
                    end
                    F_PARITY: begin
                        parity <= bit_p0;
                        fstate <= F_STOP;
                    end
                    F_STOP: begin
                        if (bit_p0 && (^{shift, parity})) begin
                            scancode       <= shift;
                            scancode_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        fstate <= F_IDLE;
                    end
                endcase
            end else if (fstate != F_IDLE) begin
                if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    fstate    <= F_IDLE;
                    tmo_cnt   <= '0;
                    frame_err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

    // Stage p2: make/break decoder, one transition per accepted byte.
    typedef enum logic [1:0] {D_NORMAL, D_BREAK, D_EXT, D_EXT_BREAK} dec_t;

    dec_t       dstate;
    logic [3:0] mapped;

    assign mapped = map_key(scancode);

    always_ff @(posedge clk) begin
        if (rst) begin
            dstate <= D_NORMAL;
            key    <= KEY_NONE;
        end else if (scancode_valid) begin
            case (dstate)
                D_NORMAL: begin
                    if (scancode == CODE_BREAK) begin
                        dstate <= D_BREAK;
                    end else if (scancode == CODE_EXT) begin
                        dstate <= D_EXT;
                    end else if (mapped != KEY_NONE) begin
                        key <= mapped;
                    end
                end
                D_BREAK: begin
                    if (mapped != KEY_NONE && mapped == key) begin
                        key <= KEY_NONE;
                    end
                    dstate <= D_NORMAL;
                end
                D_EXT: begin
                    dstate <= (scancode == CODE_BREAK) ? D_EXT_BREAK : D_NORMAL;
                end
                D_EXT_BREAK: begin
                    dstate <= D_NORMAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: bit-banged PS/2 frames, a directed vector table,
// corner-case sequences and a randomised stream checked against a sequence-level model.
`timescale 1ns/1ps
module tb_ps2_key_decoder;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF           = 16;
    localparam int GAP            = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] key;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       frame_err;

    ps2_key_decoder #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .key           (key),
        .scancode      (scancode),
        .scancode_valid(scancode_valid),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         valid_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0;
    int         valid_cyc = 0, key_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [3:0] prev_key = 4'h0;

    always @(negedge clk) begin
        if (scancode_valid) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
        if (scancode_valid && frame_err) both_cnt <= both_cnt + 1;
        if (scancode_valid && prev_valid) wide_cnt <= wide_cnt + 1;
        if (key !== prev_key) key_cyc <= cyc;
        prev_valid <= scancode_valid;
        prev_key   <= key;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    int stop_fall_cyc = 0;

    task automatic send_bit(input logic d);
        @(posedge clk);
        #1 ps2_data = d;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        stop_fall_cyc = cyc;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip, input bit bad_stop, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i]);
        ps2_data = 1'b1;
        repeat (GAP) @(posedge clk);
    endtask

    typedef struct {
        logic [7:0] code;
        bit         flip;
        bit         bad_stop;
        logic [3:0] exp_key;
        int         exp_valid;
        int         exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [3:0] key_of(input logic [7:0] c);
        case (c)
            8'h1C:   return 4'h1;
            8'h23:   return 4'h2;
            8'h1D:   return 4'h3;
            8'h1B:   return 4'h4;
            8'h24:   return 4'h5;
            default: return 4'h0;
        endcase
    endfunction

    // Sequence-level model: prefixes are collected until a terminal byte arrives.
    logic [3:0] m_key;
    logic [7:0] prefix_q[$];

    task automatic model_byte(input logic [7:0] b);
        bit         ext, brk;
        logic [3:0] k;
        if (b == 8'hF0 || b == 8'hE0) begin
            prefix_q.push_back(b);
        end else begin
            ext = 0;
            brk = 0;
            foreach (prefix_q[i]) begin
                if (prefix_q[i] == 8'hE0) ext = 1;
                if (prefix_q[i] == 8'hF0) brk = 1;
            end
            k = key_of(b);
            if (!ext) begin
                if (brk) begin
                    if (k != 4'h0 && k == m_key) m_key = 4'h0;
                end else if (k != 4'h0) begin
                    m_key = k;
                end
            end
            prefix_q.delete();
        end
    endtask

    int         v0, e0;
    logic [7:0] exp_sc;
    logic [7:0] seq[$];
    logic [7:0] pool[8];
    logic [7:0] junk;

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        pool = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h24, 8'h15, 8'h2B, 8'h76};

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset key", key, 0);
        check("reset scancode", scancode, 0);
        check("reset scancode_valid", scancode_valid, 0);
        check("reset frame_err", frame_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);

        // First frame with cycle-accurate latency checks.
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h23, 0, 0, 11);
        check("first valid count", valid_cnt - v0, 1);
        check("first err count", err_cnt - e0, 0);
        check("first scancode", scancode, 8'h23);
        check("first key", key, 4'h2);
        check("valid latency", valid_cyc - stop_fall_cyc, FILTER_LEN + 3);
        check("key latency", key_cyc - valid_cyc, 1);
        exp_sc = 8'h23;

        vecs.push_back('{8'h1C, 0, 0, 4'h1, 1, 0});
        vecs.push_back('{8'hF0, 0, 0, 4'h1, 1, 0});
        vecs.push_back('{8'h23, 0, 0, 4'h1, 1, 0});
        vecs.push_back('{8'hF0, 0, 0, 4'h1, 1, 0});
        vecs.push_back('{8'h1C, 0, 0, 4'h0, 1, 0});
        vecs.push_back('{8'h24, 0, 0, 4'h5, 1, 0});
        vecs.push_back('{8'h1C, 1, 0, 4'h5, 0, 1});
        vecs.push_back('{8'h1C, 0, 1, 4'h5, 0, 1});
        vecs.push_back('{8'hF0, 0, 0, 4'h5, 1, 0});
        vecs.push_back('{8'h24, 0, 0, 4'h0, 1, 0});
        vecs.push_back('{8'hE0, 0, 0, 4'h0, 1, 0});
        vecs.push_back('{8'h23, 0, 0, 4'h0, 1, 0});
        vecs.push_back('{8'hE0, 0, 0, 4'h0, 1, 0});
        vecs.push_back('{8'hF0, 0, 0, 4'h0, 1, 0});
        vecs.push_back('{8'h23, 0, 0, 4'h0, 1, 0});
        vecs.push_back('{8'h1B, 0, 0, 4'h4, 1, 0});
        vecs.push_back('{8'h1B, 0, 0, 4'h4, 1, 0});
        vecs.push_back('{8'h1D, 0, 0, 4'h3, 1, 0});
        vecs.push_back('{8'hF0, 0, 0, 4'h3, 1, 0});
        vecs.push_back('{8'h1B, 0, 0, 4'h3, 1, 0});
        vecs.push_back('{8'h15, 0, 0, 4'h3, 1, 0});
        vecs.push_back('{8'hF0, 0, 0, 4'h3, 1, 0});
        vecs.push_back('{8'h1D, 0, 0, 4'h0, 1, 0});
        vecs.push_back('{8'h1B, 0, 0, 4'h4, 1, 0});
        vecs.push_back('{8'hE0, 0, 0, 4'h4, 1, 0});
        vecs.push_back('{8'hF0, 0, 0, 4'h4, 1, 0});
        vecs.push_back('{8'h1B, 0, 0, 4'h4, 1, 0});
        vecs.push_back('{8'hE0, 0, 0, 4'h4, 1, 0});
        vecs.push_back('{8'h1B, 0, 0, 4'h4, 1, 0});
        vecs.push_back('{8'hF0, 0, 0, 4'h4, 1, 0});
        vecs.push_back('{8'h1B, 0, 0, 4'h0, 1, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].code, vecs[i].flip, vecs[i].bad_stop, 11);
            if (vecs[i].exp_valid != 0) exp_sc = vecs[i].code;
            check($sformatf("vec%0d valid", i), valid_cnt - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d err", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("vec%0d key", i), key, vecs[i].exp_key);
            check($sformatf("vec%0d scancode", i), scancode, exp_sc);
        end

        // Start bit of 1 while idle.
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bit(1'b1);
        repeat (GAP) @(posedge clk);
        check("bad start err", err_cnt - e0, 1);
        check("bad start valid", valid_cnt - v0, 0);

        // Partial frame abandoned until the timeout fires.
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h1D, 0, 0, 6);
        repeat (TIMEOUT_CYCLES / 2) @(posedge clk);
        check("timeout early err", err_cnt - e0, 0);
        repeat (TIMEOUT_CYCLES) @(posedge clk);
        check("timeout err", err_cnt - e0, 1);
        check("timeout valid", valid_cnt - v0, 0);
        check("timeout key", key, 4'h0);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h1D, 0, 0, 11);
        check("after timeout valid", valid_cnt - v0, 1);
        check("after timeout err", err_cnt - e0, 0);
        check("after timeout key", key, 4'h3);

        // Short low glitches on the idle clock line.
        v0 = valid_cnt;
        e0 = err_cnt;
        for (int g = 0; g < 5; g++) begin
            @(posedge clk);
            #1 ps2_clk = 1'b0;
            repeat (3) @(posedge clk);
            #1 ps2_clk = 1'b1;
            repeat (20) @(posedge clk);
        end
        check("glitch valid", valid_cnt - v0, 0);
        check("glitch err", err_cnt - e0, 0);
        send_frame(8'h1C, 0, 0, 11);
        check("after glitch valid", valid_cnt - v0, 1);
        check("after glitch err", err_cnt - e0, 0);
        check("after glitch key", key, 4'h1);

        // Reset in the middle of a frame.
        send_frame(8'h23, 0, 0, 4);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midreset key", key, 0);
        check("midreset scancode", scancode, 0);
        check("midreset valid", scancode_valid, 0);
        check("midreset err", frame_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h24, 0, 0, 11);
        check("after reset valid", valid_cnt - v0, 1);
        check("after reset err", err_cnt - e0, 0);
        check("after reset key", key, 4'h5);
        check("after reset scancode", scancode, 8'h24);

        // Randomised well-formed sequences with occasional corrupted frames.
        m_key = 4'h5;
        for (int s = 0; s < 25; s++) begin
            int kind, idx;
            kind = $urandom_range(0, 3);
            idx  = $urandom_range(0, 7);
            seq.delete();
            if (kind >= 2) seq.push_back(8'hE0);
            if (kind == 1 || kind == 3) seq.push_back(8'hF0);
            seq.push_back(pool[idx]);
            foreach (seq[j]) begin
                if ($urandom_range(0, 7) == 0) begin
                    junk = 8'($urandom);
                    v0 = valid_cnt;
                    e0 = err_cnt;
                    send_frame(junk, 1, 0, 11);
                    check($sformatf("rnd%0d corrupt err", s), err_cnt - e0, 1);
                    check($sformatf("rnd%0d corrupt valid", s), valid_cnt - v0, 0);
                    check($sformatf("rnd%0d corrupt key", s), key, m_key);
                end
                v0 = valid_cnt;
                e0 = err_cnt;
                send_frame(seq[j], 0, 0, 11);
                model_byte(seq[j]);
                check($sformatf("rnd%0d valid", s), valid_cnt - v0, 1);
                check($sformatf("rnd%0d err", s), err_cnt - e0, 0);
                check($sformatf("rnd%0d scancode", s), scancode, seq[j]);
                check($sformatf("rnd%0d key", s), key, m_key);
            end
        end

        check("valid and err overlap", both_cnt, 0);
        check("valid pulse width", wide_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Producer of the 4-bit `key` code consumed by the player movement logic. Receives PS/2 keyboard frames (scancode set 2) on the raw `ps2_clk`/`ps2_data` pins, validates framing and parity, and tracks make/break sequences. Presents the currently held game key as a registered code in the `clk` domain. Sits between the board PS/2 pins and every game block that reads `key`.

## Interface
- `FILTER_LEN`, 8: consecutive equal synchronized samples required before `ps2_clk` level is accepted (glitch filter).
- `TIMEOUT_CYCLES`, 65000: `clk` cycles without a filtered `ps2_clk` falling edge before a partial frame is discarded (1 ms at 65 MHz).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `key`  out  4  held key code, vga_pkg encoding: key_NONE=4'h0, key_A=4'h1, key_D=4'h2, key_W=4'h3, key_S=4'h4, key_E=4'h5.
- `scancode`  out  8  last valid received byte.
- `scancode_valid`  out  1  one-cycle pulse when `scancode` updates.
- `frame_err`  out  1  one-cycle pulse on parity error, bad start/stop bit, or timeout.

## Operation
- Both pins pass through 2-FF synchronizers. Filtered `ps2_clk` changes level only after `FILTER_LEN` identical synchronized samples. A falling edge of the filtered clock is a sample strobe; `ps2_data` (synchronized) is sampled at that strobe.
- Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: strobe with data=0 -> DATA, bit count 0. Strobe with data=1 -> stay IDLE, pulse `frame_err`.
  - DATA: 8 strobes, shift LSB first -> PARITY.
  - PARITY: capture bit -> STOP.
  - STOP: on strobe, the frame is valid iff stop=1 and the 8 data bits plus parity have odd weight.
    - Valid: `scancode`<=byte, pulse `scancode_valid`, pass byte to the decoder.
    - Invalid: pulse `frame_err`, discard byte.
    - In both cases -> IDLE.
- Timeout counter clears on every strobe and counts in non-IDLE states. Reaching `TIMEOUT_CYCLES` -> IDLE, pulse `frame_err`.
- Decoder FSM, one transition per valid byte: NORMAL, BREAK, EXT, EXT_BREAK.
  - NORMAL: 0xF0 -> BREAK; 0xE0 -> EXT; else make code.
  - BREAK: any byte -> break code, -> NORMAL.
  - EXT: 0xF0 -> EXT_BREAK; else discard byte (extended keys ignored) -> NORMAL.
  - EXT_BREAK: discard byte -> NORMAL.
- Make-code map: 0x1C->key_A, 0x23->key_D, 0x1D->key_W, 0x1B->key_S, 0x24->key_E. Other make codes are ignored and `key` is unchanged.
- Mapped make: `key`<=mapped code. A new key replaces the held key. A repeated (typematic) make of the same key produces no change.
- Break: if the mapped code equals `key`, then `key`<=key_NONE. A break of any other key, or of an unmapped key, is ignored.
- `frame_err` does not alter decoder state or `key`.

## Timing
- Reset values: `key`=key_NONE, `scancode`=8'h00, `scancode_valid`=0, `frame_err`=0. Both FSMs return to IDLE/NORMAL, and the timeout counter, shift register and filter counter clear.
- A mid-frame reset discards the partial byte. The next frame starts cleanly only from a fresh start bit.
- Strobe latency: 2 (sync) + `FILTER_LEN` cycles after the raw `ps2_clk` falls.
- The stop-bit strobe cycle is N. `scancode`/`scancode_valid` are registered at N+1. `key` updates at N+2, via a registered decoder stage.
- `scancode_valid` and `frame_err` never assert in the same cycle.
- All outputs are registered. No combinational path exists from the pins to the outputs.

## Test plan
- Reset, then the frame 0x23 (odd parity bit=0, stop=1): `scancode`=0x23 with a 1-cycle `scancode_valid` pulse, and `key`=4'h2 two cycles after the stop strobe.
- With D held, send 0x1C, then F0 23: `key` becomes 4'h1 on A. The break of D is ignored, so `key` stays 4'h1. Then F0 1C -> `key`=4'h0.
- Send 0x1C with the parity bit flipped: `frame_err` pulses once, `scancode_valid` stays 0, and `key` is unchanged.
- Send 5 data bits of a frame, then idle for 65000 cycles: `frame_err` pulses at the timeout and the FSM returns to IDLE. A following 0x1D frame decodes to `key`=4'h3.
- Send E0 23, then E0 F0 23: `scancode_valid` pulses 5 times and `key` stays 4'h0. Then send 0x1B: `key`=4'h4.
- Inject 3-cycle low glitches on `ps2_clk` while idle: no strobes, and no `scancode_valid` or `frame_err` pulses. Assert `rst` mid-frame: all outputs return to reset values.
